// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register sequencer.
//   state_t           : sequencer FSM states
//   CMD_RD_BIT        : command byte bit that selects read (1) or write (0)
//   DEFAULT_ERR_BYTE  : response byte returned when a read is aborted
//   tmo_width()       : bit width needed for the timeout counter
package spi_reg_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_REQ  = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        TX      = 3'd5,
        DUMMY   = 3'd6
    } state_t;

    localparam int         CMD_RD_BIT       = 7;
    localparam logic [7:0] DEFAULT_ERR_BYTE = 8'hEE;

    // The counter holds TIMEOUT_CYCLES-1 at most, so $clog2 bits suffice.
    function automatic int tmo_width(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/spi_reg_sequencer_if.sv
// Bundle of the PHY byte streams and the register bus seen by the sequencer.
//   rx_*  : Avalon-ST bytes from the SPI PHY into the sequencer
//   tx_*  : Avalon-ST bytes from the sequencer back to the PHY
//   reg_* : 8-bit register bus driven by the sequencer
// Modports: master = sequencer side, slave = PHY / register-bus side.
interface spi_reg_sequencer_if #(
    parameter int ADDR_W = 7
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [ADDR_W-1:0] reg_address;
    logic              reg_write;
    logic [7:0]        reg_writedata;
    logic              reg_read;
    logic              reg_waitrequest;
    logic [7:0]        reg_readdata;
    logic              reg_readdatavalid;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        output reg_address, reg_write, reg_writedata, reg_read,
        input  reg_waitrequest, reg_readdata, reg_readdatavalid
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        input  reg_address, reg_write, reg_writedata, reg_read,
        output reg_waitrequest, reg_readdata, reg_readdatavalid
    );
endinterface

// File: rtl/spi_reg_timeout.sv
// Loadable down-counter that flags a stalled FSM state.
//   sysclk : clock
//   reset  : synchronous active-high reset (count -> 0)
//   load   : reload to TIMEOUT_CYCLES-1 (asserted on every state change)
//   en     : count down (asserted in every non-idle state)
//   expire : the current cycle is the TIMEOUT_CYCLES-th spent in this state
module spi_reg_timeout
    import spi_reg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic sysclk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int CNT_W = tmo_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_reg;

    // expire must not depend on load: load is derived from the next state,
    // which in turn depends on expire.
    assign expire = en && (cnt_reg == '0);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end
endmodule

// File: rtl/spi_reg_sequencer.sv
// Decodes SPI byte commands into register-bus reads/writes.
//   sysclk, reset : clock and synchronous active-high reset
//   bus           : PHY rx/tx byte streams and register bus (master side)
//   err_timeout   : sticky flag, set by any timeout abort
//   busy          : high whenever the FSM is not idle
// Protocol: cmd byte (bit7=1 read, bits[6:0] address); a write is followed by
// one data byte; a read returns one byte, during which the master clocks in
// one dummy byte that is consumed and discarded.
module spi_reg_sequencer
    import spi_reg_pkg::*;
#(
    parameter int         ADDR_W         = 7,
    parameter int         TIMEOUT_CYCLES = 65535,
    parameter logic [7:0] ERR_BYTE       = DEFAULT_ERR_BYTE
) (
    input  logic                sysclk,
    input  logic                reset,
    spi_reg_sequencer_if.master bus,
    output logic                err_timeout,
    output logic                busy
);
    state_t state_reg, state_next;

    // Handshake outputs are registered from the next state so that every
    // output reads 0 while in reset, including the rx_ready of IDLE.
    logic rx_ready_reg, rx_ready_next;
    logic tx_valid_reg, tx_valid_next;
    logic reg_write_reg, reg_write_next;
    logic reg_read_reg, reg_read_next;
    logic busy_reg, busy_next;

    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        wdata_reg;
    logic [7:0]        tx_data_reg;
    logic              err_reg;

    logic rx_acc, tx_acc, wr_done, rd_done;
    logic expire, abort;

    assign rx_acc  = bus.rx_valid && rx_ready_reg;
    assign tx_acc  = tx_valid_reg && bus.tx_ready;
    assign wr_done = reg_write_reg && !bus.reg_waitrequest;
    assign rd_done = reg_read_reg && !bus.reg_waitrequest;

    spi_reg_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .sysclk (sysclk),
        .reset  (reset),
        .load   (state_next != state_reg),
        .en     (state_reg != IDLE),
        .expire (expire)
    );

    // State register
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; normal progress always beats a coincident expiry.
    always_comb begin
        state_next = state_reg;
        abort      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rx_acc) begin
                    state_next = bus.rx_data[CMD_RD_BIT] ? RD_REQ : WR_DATA;
                end
            end
            WR_DATA: begin
                if (rx_acc) begin
                    state_next = WR_REQ;
                end else if (expire) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end
            end
            WR_REQ: begin
                if (wr_done) begin
                    state_next = IDLE;
                end else if (expire) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end
            end
            RD_REQ: begin
                if (rd_done) begin
                    state_next = bus.reg_readdatavalid ? TX : RD_WAIT;
                end else if (expire) begin
                    // Still answer the master, with the error byte.
                    state_next = TX;
                    abort      = 1'b1;
                end
            end
            RD_WAIT: begin
                if (bus.reg_readdatavalid) begin
                    state_next = TX;
                end else if (expire) begin
                    state_next = TX;
                    abort      = 1'b1;
                end
            end
            TX: begin
                if (tx_acc) begin
                    state_next = DUMMY;
                end else if (expire) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end
            end
            DUMMY: begin
                if (rx_acc) begin
                    state_next = IDLE;
                end else if (expire) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode of the state being entered.
    always_comb begin
        rx_ready_next  = (state_next == IDLE) || (state_next == WR_DATA) ||
                         (state_next == DUMMY);
        tx_valid_next  = (state_next == TX);
        reg_write_next = (state_next == WR_REQ);
        reg_read_next  = (state_next == RD_REQ);
        busy_next      = (state_next != IDLE);
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_ready_reg  <= 1'b0;
            tx_valid_reg  <= 1'b0;
            reg_write_reg <= 1'b0;
            reg_read_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            rx_ready_reg  <= rx_ready_next;
            tx_valid_reg  <= tx_valid_next;
            reg_write_reg <= reg_write_next;
            reg_read_reg  <= reg_read_next;
            busy_reg      <= busy_next;
        end
    end

    // Datapath: address, write data, response byte, sticky error.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            addr_reg    <= '0;
            wdata_reg   <= '0;
            tx_data_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            if ((state_reg == IDLE) && rx_acc) begin
                addr_reg <= bus.rx_data[ADDR_W-1:0];
            end
            if ((state_reg == WR_DATA) && rx_acc) begin
                wdata_reg <= bus.rx_data;
            end
            if ((state_next == TX) &&
                ((state_reg == RD_REQ) || (state_reg == RD_WAIT))) begin
                tx_data_reg <= abort ? ERR_BYTE : bus.reg_readdata;
            end
            if (abort) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bus.rx_ready      = rx_ready_reg;
    assign bus.tx_valid      = tx_valid_reg;
    assign bus.tx_data       = tx_data_reg;
    assign bus.reg_write     = reg_write_reg;
    assign bus.reg_read      = reg_read_reg;
    assign bus.reg_address   = addr_reg;
    assign bus.reg_writedata = wdata_reg;
    assign err_timeout       = err_reg;
    assign busy              = busy_reg;
endmodule
